// File: rtl/gmii_frame_gen_pkg.sv
// gmii_frame_gen_pkg
// Shared definitions for the GMII test-frame generator: FSM state encodings,
// fixed frame bytes, CRC32 constants and frame-section lengths.
package gmii_frame_gen_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_PREAMBLE = 3'd1;
    localparam state_t ST_SFD      = 3'd2;
    localparam state_t ST_HEADER   = 3'd3;
    localparam state_t ST_PAYLOAD  = 3'd4;
    localparam state_t ST_FCS      = 3'd5;
    localparam state_t ST_IFG      = 3'd6;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    localparam logic [10:0] MIN_PAYLOAD = 11'd46;
    localparam logic [10:0] MAX_PAYLOAD = 11'd1500;

    localparam int PREAMBLE_LEN = 7;
    localparam int HDR_LEN      = 14;
    localparam int FCS_LEN      = 4;

    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        logic [10:0] r;
        r = len;
        if (len < MIN_PAYLOAD) r = MIN_PAYLOAD;
        else if (len > MAX_PAYLOAD) r = MAX_PAYLOAD;
        return r;
    endfunction

endpackage

// File: rtl/gmii_frame_gen_crc32_step.sv
// gmii_crc32_step
// Combinational Ethernet CRC32 update for one byte, reflected form,
// data consumed LSB first.
//   crc_in  [31:0]  running CRC register value
//   data    [7:0]   byte to fold in
//   crc_out [31:0]  CRC register after the byte
module gmii_crc32_step
    import gmii_frame_gen_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_frame_gen.sv
// gmii_frame_gen
// GMII Ethernet test-frame transmitter: preamble/SFD, fixed header,
// sequence-numbered counting payload, CRC32 FCS and inter-frame gap.
//   clk          GMII byte clock
//   rst          synchronous active-high reset
//   clk_enable   byte-time qualifier; all state advances only when 1
//   start        frame request (queues one frame if already busy)
//   payload_len  payload byte count, clamped to 46..1500 at acceptance
//   gmii_txd     transmit data
//   gmii_tx_en   transmit enable
//   gmii_tx_er   transmit error, tied low
//   busy         acceptance through last IFG byte-time
//   frame_done   one-cycle pulse alongside the last FCS byte
//   frames_sent  completed frame count (wraps)
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for start, line idle
// PREAMBLE | driving 7 x 0x55
// SFD      | driving 0xD5, CRC reloaded
// HEADER   | driving DST_MAC, SRC_MAC, ETHERTYPE
// PAYLOAD  | driving seq (4 bytes BE) then counting bytes
// FCS      | driving ~crc, least significant byte first
// IFG      | IFG_CYCLES idle byte-times, then next frame or IDLE
//
// The state register names the section of the byte currently on gmii_txd;
// cnt is a down-counter of bytes still to come in that section.
module gmii_frame_gen
    import gmii_frame_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [10:0] payload_len,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] frames_sent
);

    localparam logic [111:0] HDR_BITS = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [10:0]  PRE_LAST = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0]  HDR_LAST = 11'(HDR_LEN - 1);
    localparam logic [10:0]  FCS_LAST = 11'(FCS_LEN - 1);
    localparam logic [10:0]  IFG_LAST = 11'(IFG_CYCLES - 1);

    state_t      state;
    logic [10:0] cnt;
    logic [10:0] pay_idx;
    logic [10:0] len_q;
    logic [31:0] seq_q;
    logic [31:0] crc_q;
    logic        pending;

    state_t      nxt_state;
    logic [10:0] nxt_cnt;
    logic [10:0] nxt_pay_idx;
    logic [7:0]  nxt_txd;
    logic        nxt_tx_en;
    logic        nxt_done;
    logic        load_frame;
    logic [31:0] crc_step_out;

    // Header byte selected by the remaining-bytes count of the HEADER section.
    function automatic logic [7:0] hdr_byte(input logic [10:0] remaining);
        int           idx;
        logic [111:0] sh;
        idx = int'(HDR_LAST) - int'(remaining);
        sh  = HDR_BITS << (8 * idx);
        return sh[111:104];
    endfunction

    function automatic logic [7:0] payload_byte(input logic [10:0] idx,
                                                input logic [31:0] seq);
        logic [31:0] sh;
        logic [10:0] off;
        sh  = seq << (8 * int'(idx[1:0]));
        off = idx - 11'd4;
        if (idx < 11'd4) return sh[31:24];
        return off[7:0];
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [10:0] remaining,
                                            input logic [31:0] crc);
        int          idx;
        logic [31:0] sh;
        idx = int'(FCS_LAST) - int'(remaining);
        sh  = ~crc >> (8 * idx);
        return sh[7:0];
    endfunction

    gmii_crc32_step u_crc_step (
        .crc_in  (crc_q),
        .data    (nxt_txd),
        .crc_out (crc_step_out)
    );

    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_pay_idx = pay_idx;
        nxt_done    = 1'b0;
        load_frame  = 1'b0;
        nxt_txd     = 8'h00;
        nxt_tx_en   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_frame = 1'b1;
                    nxt_state  = ST_PREAMBLE;
                    nxt_cnt    = PRE_LAST;
                end
            end
            ST_PREAMBLE: begin
                if (cnt != 11'd0) begin
                    nxt_cnt = cnt - 11'd1;
                end else begin
                    nxt_state = ST_SFD;
                    nxt_cnt   = 11'd0;
                end
            end
            ST_SFD: begin
                nxt_state = ST_HEADER;
                nxt_cnt   = HDR_LAST;
            end
            ST_HEADER: begin
                if (cnt != 11'd0) begin
                    nxt_cnt = cnt - 11'd1;
                end else begin
                    nxt_state   = ST_PAYLOAD;
                    nxt_cnt     = len_q - 11'd1;
                    nxt_pay_idx = 11'd0;
                end
            end
            ST_PAYLOAD: begin
                if (cnt != 11'd0) begin
                    nxt_cnt     = cnt - 11'd1;
                    nxt_pay_idx = pay_idx + 11'd1;
                end else begin
                    nxt_state = ST_FCS;
                    nxt_cnt   = FCS_LAST;
                end
            end
            ST_FCS: begin
                if (cnt != 11'd0) begin
                    nxt_cnt  = cnt - 11'd1;
                    nxt_done = (cnt == 11'd1);
                end else begin
                    nxt_state = ST_IFG;
                    nxt_cnt   = IFG_LAST;
                end
            end
            ST_IFG: begin
                if (cnt != 11'd0) begin
                    nxt_cnt = cnt - 11'd1;
                end else if (pending || start) begin
                    load_frame = 1'b1;
                    nxt_state  = ST_PREAMBLE;
                    nxt_cnt    = PRE_LAST;
                end else begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = 11'd0;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = 11'd0;
            end
        endcase

        // Output byte is derived from where the FSM is going, so it lands in
        // the output register on the same edge as the state change.
        case (nxt_state)
            ST_PREAMBLE: begin
                nxt_txd   = PREAMBLE_BYTE;
                nxt_tx_en = 1'b1;
            end
            ST_SFD: begin
                nxt_txd   = SFD_BYTE;
                nxt_tx_en = 1'b1;
            end
            ST_HEADER: begin
                nxt_txd   = hdr_byte(nxt_cnt);
                nxt_tx_en = 1'b1;
            end
            ST_PAYLOAD: begin
                nxt_txd   = payload_byte(nxt_pay_idx, seq_q);
                nxt_tx_en = 1'b1;
            end
            ST_FCS: begin
                nxt_txd   = fcs_byte(nxt_cnt, crc_q);
                nxt_tx_en = 1'b1;
            end
            default: begin
                nxt_txd   = 8'h00;
                nxt_tx_en = 1'b0;
            end
        endcase
    end

    assign gmii_tx_er = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 11'd0;
            pay_idx     <= 11'd0;
            len_q       <= MIN_PAYLOAD;
            seq_q       <= 32'd0;
            crc_q       <= CRC_INIT;
            pending     <= 1'b0;
            gmii_txd    <= 8'h00;
            gmii_tx_en  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= 32'd0;
        end else if (clk_enable) begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            pay_idx    <= nxt_pay_idx;
            gmii_txd   <= nxt_txd;
            gmii_tx_en <= nxt_tx_en;
            busy       <= (nxt_state != ST_IDLE);
            frame_done <= nxt_done;
            if (nxt_done) frames_sent <= frames_sent + 32'd1;

            // A start during an active frame is remembered once; a start
            // landing on the last IFG byte-time is taken directly instead.
            if (load_frame) begin
                len_q   <= clamp_len(payload_len);
                seq_q   <= frames_sent;
                pending <= 1'b0;
            end else if (start && state != ST_IDLE) begin
                pending <= 1'b1;
            end

            if (nxt_state == ST_SFD) begin
                crc_q <= CRC_INIT;
            end else if (nxt_state == ST_HEADER || nxt_state == ST_PAYLOAD) begin
                crc_q <= crc_step_out;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gmii_frame_gen.sv
module tb_gmii_frame_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    logic [10:0] payload_len = 11'd46;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        frame_done;
    logic [31:0] frames_sent;

    int errors = 0;
    int checks = 0;

    localparam logic [111:0] TB_HDR = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};

    always #4 clk = ~clk;

    gmii_frame_gen dut (
        .clk         (clk),
        .rst         (rst),
        .clk_enable  (clk_enable),
        .start       (start),
        .payload_len (payload_len),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    // scoreboard
    logic [7:0]  exp_bytes[$];
    int          exp_lens[$];
    logic [31:0] exp_seqs[$];
    logic [31:0] next_seq = 32'd0;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push_frame(input int len_in, input logic [31:0] seq);
        int          len;
        logic [31:0] crc;
        logic [7:0]  fr[$];
        logic [7:0]  b;
        len = (len_in < 46) ? 46 : (len_in > 1500) ? 1500 : len_in;
        for (int i = 0; i < 7; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        for (int i = 0; i < 14; i++) begin
            b = TB_HDR[111 - 8*i -: 8];
            fr.push_back(b);
        end
        for (int i = 0; i < len; i++) begin
            if (i < 4) b = seq[31 - 8*i -: 8];
            else       b = 8'((i - 4) % 256);
            fr.push_back(b);
        end
        crc = 32'hFFFFFFFF;
        for (int i = 8; i < fr.size(); i++) crc = crc_upd(crc, fr[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) begin
            b = crc[8*i +: 8];
            fr.push_back(b);
        end
        foreach (fr[i]) exp_bytes.push_back(fr[i]);
        exp_lens.push_back(8 + 14 + len + 4);
        exp_seqs.push_back(seq);
    endtask

    // monitor
    logic        s_en = 1'b1;
    logic        s_rst = 1'b1;
    logic        in_frame = 1'b0;
    int          cur_cnt = 0;
    int          cur_exp_len = -1;
    logic [31:0] cur_seq = 32'd0;
    logic [31:0] res_crc = 32'hFFFFFFFF;
    logic [7:0]  cap[0:1599];
    logic [7:0]  last_frame[0:1599];
    int          last_len = 0;
    int          gap_cnt = 0;
    int          last_gap = 0;
    int          frames_seen = 0;
    logic [7:0]  prev_txd = 8'h00;
    logic        prev_en = 1'b0;

    always @(posedge clk) begin
        s_en  = clk_enable;
        s_rst = rst;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        logic       exp_done;
        if (s_rst) begin
            in_frame = 1'b0;
            cur_cnt  = 0;
            gap_cnt  = 0;
            exp_bytes.delete();
            exp_lens.delete();
            exp_seqs.delete();
            prev_txd = 8'h00;
            prev_en  = 1'b0;
        end else if (!s_en) begin
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL frame_done_disabled got=%b required=0", frame_done);
            end
            checks++;
            if (gmii_txd !== prev_txd || gmii_tx_en !== prev_en) begin
                errors++;
                $display("FAIL hold_disabled got=%h/%b required=%h/%b", gmii_txd, gmii_tx_en, prev_txd, prev_en);
            end
        end else begin
            if (gmii_tx_en === 1'b1) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur_cnt  = 0;
                    last_gap = gap_cnt;
                    res_crc  = 32'hFFFFFFFF;
                    checks++;
                    if (exp_lens.size() == 0) begin
                        errors++;
                        cur_exp_len = -1;
                        $display("FAIL unexpected_frame got=frame required=none");
                    end else begin
                        cur_exp_len = exp_lens.pop_front();
                        cur_seq     = exp_seqs.pop_front();
                    end
                end
                if (cur_cnt < 1600) cap[cur_cnt] = gmii_txd;
                if (cur_cnt >= 8) res_crc = crc_upd(res_crc, gmii_txd);
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte idx=%0d got=%h required=none", cur_cnt, gmii_txd);
                end else begin
                    e = exp_bytes.pop_front();
                    if (gmii_txd !== e) begin
                        errors++;
                        $display("FAIL txd_byte idx=%0d got=%h required=%h", cur_cnt, gmii_txd, e);
                    end
                end
                cur_cnt++;
                exp_done = (cur_cnt == cur_exp_len);
                checks++;
                if (frame_done !== exp_done) begin
                    errors++;
                    $display("FAIL frame_done idx=%0d got=%b required=%b", cur_cnt - 1, frame_done, exp_done);
                end
                if (exp_done) begin
                    checks++;
                    if (frames_sent !== cur_seq + 32'd1) begin
                        errors++;
                        $display("FAIL frames_sent_at_done got=%h required=%h", frames_sent, cur_seq + 32'd1);
                    end
                end
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    checks++;
                    if (cur_cnt != cur_exp_len) begin
                        errors++;
                        $display("FAIL tx_en_len got=%0d required=%0d", cur_cnt, cur_exp_len);
                    end
                    checks++;
                    if (res_crc !== 32'hDEBB20E3) begin
                        errors++;
                        $display("FAIL crc_residue got=%h required=DEBB20E3", res_crc);
                    end
                    last_len = cur_cnt;
                    for (int i = 0; i < 1600; i++) last_frame[i] = cap[i];
                    gap_cnt = 0;
                    frames_seen++;
                end
                gap_cnt++;
                checks++;
                if (frame_done !== 1'b0 || gmii_txd !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_line got=%h/%b required=00/0", gmii_txd, frame_done);
                end
            end
            checks++;
            if (gmii_tx_er !== 1'b0) begin
                errors++;
                $display("FAIL tx_er got=%b required=0", gmii_tx_er);
            end
            prev_txd = gmii_txd;
            prev_en  = gmii_tx_en;
        end
    end

    // helpers
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (frames_seen < target) begin
            errors++;
            $display("FAIL timeout_%s frames_seen=%0d required=%0d", name, frames_seen, target);
        end
    endtask

    task automatic send_frame(input int len);
        step();
        start       = 1'b1;
        payload_len = 11'(len);
        push_frame(len, next_seq);
        next_seq    = next_seq + 32'd1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        repeat (4) step();
        rst      = 1'b0;
        next_seq = 32'd0;
    endtask

    task automatic check_byte(input string name, input int idx, input logic [7:0] req);
        checks++;
        if (last_frame[idx] !== req) begin
            errors++;
            $display("FAIL %s idx=%0d got=%h required=%h", name, idx, last_frame[idx], req);
        end
    endtask

    // tests
    task automatic test_reset();
        rst        = 1'b1;
        clk_enable = 1'b1;
        start      = 1'b0;
        repeat (4) step();
        checks++; if (gmii_txd !== 8'h00)     begin errors++; $display("FAIL rst_txd got=%h required=00", gmii_txd); end
        checks++; if (gmii_tx_en !== 1'b0)    begin errors++; $display("FAIL rst_tx_en got=%b required=0", gmii_tx_en); end
        checks++; if (gmii_tx_er !== 1'b0)    begin errors++; $display("FAIL rst_tx_er got=%b required=0", gmii_tx_er); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy got=%b required=0", busy); end
        checks++; if (frame_done !== 1'b0)    begin errors++; $display("FAIL rst_frame_done got=%b required=0", frame_done); end
        checks++; if (frames_sent !== 32'd0)  begin errors++; $display("FAIL rst_frames_sent got=%h required=0", frames_sent); end
        rst      = 1'b0;
        next_seq = 32'd0;
    endtask

    task automatic test_min_frame();
        int base;
        base = frames_seen;
        step();
        start       = 1'b1;
        payload_len = 11'd46;
        push_frame(46, next_seq);
        next_seq    = next_seq + 32'd1;
        step();
        start = 1'b0;
        checks++;
        if (gmii_tx_en !== 1'b1 || gmii_txd !== 8'h55 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_byte_latency got=%h/%b/%b required=55/1/1", gmii_txd, gmii_tx_en, busy);
        end
        wait_frames(base + 1, 200, "min_frame");
        checks++;
        if (last_len != 72) begin errors++; $display("FAIL min_len got=%0d required=72", last_len); end
        for (int i = 0; i < 7; i++) check_byte("min_preamble", i, 8'h55);
        check_byte("min_sfd", 7, 8'hD5);
        for (int i = 0; i < 5; i++) check_byte("min_payload_head", 22 + i, 8'h00);
        check_byte("min_payload_45", 22 + 45, 8'h29);
        checks++;
        if (frames_sent !== 32'd1) begin errors++; $display("FAIL min_frames_sent got=%h required=1", frames_sent); end
    endtask

    task automatic test_clamp();
        int base;
        base = frames_seen;
        send_frame(10);
        wait_frames(base + 1, 200, "clamp_low");
        checks++;
        if (last_len != 72) begin errors++; $display("FAIL clamp_low_len got=%0d required=72", last_len); end
        send_frame(2047);
        wait_frames(base + 2, 2000, "clamp_high");
        checks++;
        if (last_len != 1526) begin errors++; $display("FAIL clamp_high_len got=%0d required=1526", last_len); end
        check_byte("clamp_high_last_payload", 22 + 1499, 8'hD7);
    endtask

    task automatic test_enable_toggle();
        int base;
        int n;
        base = frames_seen;
        step();
        clk_enable  = 1'b1;
        start       = 1'b1;
        payload_len = 11'd60;
        push_frame(60, next_seq);
        next_seq    = next_seq + 32'd1;
        step();
        start = 1'b0;
        n = 0;
        while (frames_seen < base + 1 && n < 600) begin
            clk_enable = ~clk_enable;
            step();
            n++;
        end
        clk_enable = 1'b1;
        checks++;
        if (frames_seen < base + 1) begin errors++; $display("FAIL timeout_enable_toggle frames_seen=%0d required=%0d", frames_seen, base + 1); end
        checks++;
        if (last_len != 86) begin errors++; $display("FAIL toggle_len got=%0d required=86", last_len); end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = frames_seen;
        for (int k = 0; k < 4; k++) push_frame(46, 32'(k));
        next_seq    = 32'd4;
        start       = 1'b1;
        payload_len = 11'd46;
        repeat (200) step();
        start = 1'b0;
        wait_frames(base + 2, 400, "b2b_second");
        checks++;
        if (last_gap != 12) begin errors++; $display("FAIL b2b_gap2 got=%0d required=12", last_gap); end
        check_byte("b2b_seq0", 22, 8'h00);
        check_byte("b2b_seq1", 23, 8'h00);
        check_byte("b2b_seq2", 24, 8'h00);
        check_byte("b2b_seq3", 25, 8'h01);
        wait_frames(base + 4, 400, "b2b_fourth");
        checks++;
        if (last_gap != 12) begin errors++; $display("FAIL b2b_gap4 got=%0d required=12", last_gap); end
        repeat (200) step();
        checks++;
        if (frames_seen != base + 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_single_pending frames=%0d busy=%b required=%0d/0", frames_seen - base, busy, 4);
        end
        checks++;
        if (frames_sent !== 32'd4) begin errors++; $display("FAIL b2b_frames_sent got=%h required=4", frames_sent); end
    endtask

    task automatic test_reset_mid();
        int base;
        int n;
        send_frame(46);
        n = 0;
        while (!(in_frame && cur_cnt == 43) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL timeout_reset_mid cur_cnt=%0d required=43", cur_cnt); end
        rst = 1'b1;
        step();
        checks++; if (gmii_tx_en !== 1'b0)   begin errors++; $display("FAIL mid_rst_tx_en got=%b required=0", gmii_tx_en); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL mid_rst_busy got=%b required=0", busy); end
        checks++; if (frames_sent !== 32'd0) begin errors++; $display("FAIL mid_rst_frames_sent got=%h required=0", frames_sent); end
        rst      = 1'b0;
        next_seq = 32'd0;
        step();
        base = frames_seen;
        send_frame(46);
        wait_frames(base + 1, 200, "after_reset");
        for (int i = 0; i < 4; i++) check_byte("after_reset_seq", 22 + i, 8'h00);
    endtask

    task automatic test_wrap();
        int base;
        base = frames_seen;
        step();
        force dut.frames_sent = 32'hFFFF_FFFF;
        start       = 1'b1;
        payload_len = 11'd46;
        push_frame(46, 32'hFFFF_FFFF);
        next_seq    = 32'd0;
        step();
        start = 1'b0;
        release dut.frames_sent;
        wait_frames(base + 1, 200, "wrap");
        for (int i = 0; i < 4; i++) check_byte("wrap_seq", 22 + i, 8'hFF);
        checks++;
        if (frames_sent !== 32'd0) begin errors++; $display("FAIL wrap_frames_sent got=%h required=0", frames_sent); end
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_clamp();
        test_enable_toggle();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gmii_frame_gen.md
Name: gmii_frame_gen

Overview:
GMII-side Ethernet test-frame transmitter. It drives gmii_txd/tx_en/tx_er into the PCS/PMA transmit path, which makes it the sending peer of the MAC's GMII receive path. Each frame is fully formed: preamble/SFD, fixed header, sequence-numbered counting payload, CRC32 FCS and inter-frame gap. It is used for link bring-up and for loopback tests against eth_mac_1g receive.

Parameters:
DST_MAC, 48'hFFFF_FFFF_FFFF, destination address, sent MSB byte first.
SRC_MAC, 48'h02_00_00_00_00_01, source address, sent MSB byte first.
ETHERTYPE, 16'h88B5, EtherType field, sent MSB byte first.
IFG_CYCLES, 12, idle byte-times after the FCS. Legal range is 12..255.

Ports:
clk  input  1  GMII byte clock (phy_gmii_clk domain).
rst  input  1  Reset. Synchronous, active-high.
clk_enable  input  1  Byte-time qualifier. All state advances only when this is 1.
start  input  1  Request one frame. Sampled on enabled cycles.
payload_len  input  11  Payload byte count, sampled when a frame is accepted.
gmii_txd  output  8  Transmit data.
gmii_tx_en  output  1  Transmit enable.
gmii_tx_er  output  1  Transmit error. Always 0.
busy  output  1  High from frame acceptance through the last IFG cycle.
frame_done  output  1  One-cycle pulse on the last FCS byte.
frames_sent  output  32  Count of completed frames. Wraps modulo 2^32.

Behaviour:
- Reset values: gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, busy=0, frame_done=0, frames_sent=0. State returns to IDLE and the pending flag clears.
- All outputs are registered.
- clk_enable=0 freezes state, counters and CRC. Outputs hold their values, except frame_done, which is forced to 0.
- FSM states: IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG.
- IDLE: start=1 accepts a frame. On the accept cycle:
  - len = payload_len clamped to [46,1500];
  - seq = frames_sent is latched;
  - state goes to PREAMBLE.
- PREAMBLE: 7 bytes of 0x55, tx_en=1.
- SFD: 1 byte, 0xD5.
- HEADER: 14 bytes, DST_MAC, then SRC_MAC, then ETHERTYPE.
- PAYLOAD: len bytes.
  - Bytes 0..3 are seq, big-endian.
  - Byte i for i>=4 is (i-4) mod 256.
- FCS: 4 bytes, ~crc, least significant byte first.
- IFG: IFG_CYCLES cycles with tx_en=0 and txd=0. Then go to PREAMBLE if a start is pending, else IDLE.
- Latency: if start is accepted on enabled cycle N, the first 0x55 appears on enabled cycle N+1.
- Frame length: tx_en stays high for exactly 8+14+len+4 contiguous enabled cycles.
- CRC32:
  - reflected polynomial 0xEDB88320;
  - init 0xFFFFFFFF, reloaded at SFD;
  - updated on every HEADER and PAYLOAD byte, LSB-first bitwise per byte;
  - preamble and SFD are not included.
- start while busy: a single pending flag is set; further starts are dropped. The pending frame samples payload_len and seq when it leaves IFG. This gives back-to-back frames with exactly IFG_CYCLES idle cycles between them.
- frames_sent increments on the same cycle frame_done pulses.
- Reset mid-frame: on the rising edge with rst=1 the outputs go to their reset values. The truncated frame is not counted.
- gmii_tx_er is tied to 0 and never asserted.

Decomposition:
- Package gmii_frame_gen_pkg holds:
  - the state enum;
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF;
  - MIN_PAYLOAD=46 and MAX_PAYLOAD=1500;
  - HDR_LEN=14 and FCS_LEN=4.
- One sub-module, gmii_crc32_step: a combinational 8-bit-per-step CRC update taking crc_in[31:0] and data[7:0] and producing crc_out[31:0]. The top level owns the CRC register.

Test Plan:
1. Minimum frame: rst for 4 cycles; clk_enable=1; start pulse with payload_len=46.
   - Tx_en high for 72 cycles.
   - Bytes 0..7 are 55×7, D5.
   - Payload bytes 0..3 are 00 00 00 00, payload byte 4 is 00, byte 45 is 29.
   - frame_done on cycle 72; frames_sent=1.
   - CRC over header+payload+FCS gives residue 0xDEBB20E3.
2. Clamping:
   - payload_len=10 gives 72 tx_en cycles;
   - payload_len=2047 gives 1526 cycles (1500-byte payload).
3. Back-to-back: start held high for 200 cycles with payload_len=46.
   - tx_en low for exactly 12 cycles between frames.
   - Second frame's payload bytes 0..3 are 00 00 00 01.
   - Only one pending frame is queued.
4. clk_enable=0 on alternate cycles, payload_len=60: the txd sequence on enabled cycles is identical to the always-enabled run, and frame_done is never high on a disabled cycle.
5. Reset mid-PAYLOAD: rst=1 at payload byte 20.
   - Next cycle tx_en=0, busy=0, frames_sent=0.
   - A subsequent start produces a clean frame with seq 00 00 00 00.
6. Counter wrap: force frames_sent to 32'hFFFF_FFFF and send a frame.
   - Payload bytes 0..3 are FF FF FF FF.
   - frames_sent becomes 0 after frame_done.
